// File: rtl/mealy_ctx_arbiter_if.sv
// Request/response bundle for mealy_ctx_arbiter: per-requester valid/symbol/grant
// lanes plus the single registered response channel.
interface mealy_ctx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_in;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [1:0]           rsp_out;
  logic                 rsp_state;

  // Requester agents and the response consumer
  modport master (
    output req_valid, req_in, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_state
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_in, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_state
  );
endinterface

// File: rtl/mealy_ctx_arbiter.sv
// One Blue/Red Mealy machine time-shared between NUM_REQ requesters, each with its
// own saved state bit; round-robin grant, registered response, saturating change count.
module mealy_ctx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNTW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  mealy_ctx_arbiter_if.slave  bus,
  input  logic                ctx_clear,
  output logic [CNTW-1:0]     trans_cnt
);
  localparam int IDW = $clog2(NUM_REQ);

  // S_HOLD: the output register carries a response the consumer has not yet taken.
  typedef enum logic {
    S_RUN  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_ctx;
  logic [IDW-1:0]     r_ptr;
  logic [IDW-1:0]     r_rsp_id;
  logic [1:0]         r_rsp_out;
  logic               r_rsp_state;
  logic [CNTW-1:0]    r_cnt;

  logic               w_accept;
  logic               w_gnt_any;
  logic [IDW-1:0]     w_gnt_idx;
  logic               w_xfer;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_sel_s;
  logic [1:0]         w_sel_x;
  logic [2:0]         w_step;
  logic               w_next;
  logic [1:0]         w_out;
  logic [IDW-1:0]     w_ptr_nxt;

  // Returns {next_state, out}; Red=1. Only x==1 flips the colour.
  function automatic logic [2:0] mealy_step(input logic s, input logic [1:0] x);
    logic nxt;
    nxt = (x == 2'd1) ? ~s : s;
    return {nxt, (nxt ? 2'd2 : 2'd1)};
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_accept = !ctx_clear && (r_state == S_RUN || bus.rsp_ready);

  // First valid requester at or after the pointer, wrapping; independent of req_in.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_gnt_any && bus.req_valid[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'(idx);
      end
    end
  end

  assign w_xfer = w_accept && w_gnt_any;

  always_comb begin
    w_ready = '0;
    if (w_xfer) w_ready[w_gnt_idx] = 1'b1;
  end

  assign w_sel_s   = r_ctx[w_gnt_idx];
  assign w_sel_x   = bus.req_in[{w_gnt_idx, 1'b0} +: 2];
  assign w_step    = mealy_step(w_sel_s, w_sel_x);
  assign w_next    = w_step[2];
  assign w_out     = w_step[1:0];
  assign w_ptr_nxt = (w_gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : IDW'(w_gnt_idx + 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_ctx       <= '1;
      r_ptr       <= '0;
      r_rsp_id    <= '0;
      r_rsp_out   <= 2'd0;
      r_rsp_state <= 1'b1;
      r_cnt       <= '0;
    end else begin
      // A clear blocks grants, so it never races a context write-back.
      if (ctx_clear)   r_ctx            <= '1;
      else if (w_xfer) r_ctx[w_gnt_idx] <= w_next;

      if (w_xfer) begin
        r_state     <= S_HOLD;
        r_rsp_id    <= w_gnt_idx;
        r_rsp_out   <= w_out;
        r_rsp_state <= w_next;
        r_ptr       <= w_ptr_nxt;
        if (w_next != w_sel_s) r_cnt <= sat_inc(r_cnt);
      end else if (bus.rsp_ready) begin
        r_state <= S_RUN;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == S_HOLD);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_out   = r_rsp_out;
  assign bus.rsp_state = r_rsp_state;
  assign trans_cnt     = r_cnt;

endmodule

// File: doc/mealy_ctx_arbiter.md
Name: mealy_ctx_arbiter

Overview:
- Shares one two-state Blue/Red Mealy color machine between NUM_REQ independent requesters.
- Each requester has its own saved state context. Each cycle the block grants one requester round-robin, evaluates the Mealy function on that requester's context and input, writes the next state back, and returns the output on a registered response channel.
- Sits between requester agents and the downstream consumer of the 2-bit color output.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDW, $clog2(NUM_REQ), requester id width (derived, not overridable).
- CNTW, 16, width of the transition counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_in  input  2*NUM_REQ  per-requester 2-bit input symbol; requester i uses bits [2i+1:2i].
- req_ready  output  NUM_REQ  one-hot grant; combinational.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  IDW  id of the requester being answered.
- rsp_out  output  2  Mealy output for that request.
- rsp_state  output  1  new state written back (0=Blue, 1=Red).
- ctx_clear  input  1  synchronous clear of all contexts.
- trans_cnt  output  CNTW  saturating count of state changes.

Behaviour:
- Mealy function, with s = stored context and x = input:
  - s=Blue: if x==1 then next=Red, out=2; otherwise next=Blue, out=1.
  - s=Red: if x==1 then next=Blue, out=1; otherwise next=Red, out=2 (covers x=0, 2 and 3).
- Reset values:
  - All contexts = Red.
  - rsp_valid=0; rsp_id=0; rsp_out=0; rsp_state=1; trans_cnt=0.
  - Round-robin pointer = 0, so requester 0 has highest priority.
- Controller FSM has two states:
  - RUN: the output register is free or being drained this cycle.
  - HOLD: rsp_valid=1 and rsp_ready=0.
- Grant rule:
  - accept = !ctx_clear && (!rsp_valid || rsp_ready).
  - When accept is true, req_ready is one-hot on the first requester with req_valid, searching from the pointer upward and wrapping modulo NUM_REQ.
  - When accept is false, req_ready = 0.
  - req_ready never depends on req_in.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. On the clock edge of a transfer:
  - context[i] <= next;
  - rsp_valid <= 1; rsp_id <= i; rsp_out <= out; rsp_state <= next;
  - pointer <= (i+1) mod NUM_REQ.
- Latency:
  - The response appears exactly 1 cycle after the grant.
  - Sustained throughput is 1 request/cycle while rsp_ready=1.
- Response draining:
  - rsp_ready=1 with no new transfer: rsp_valid <= 0.
  - rsp_valid=1 and rsp_ready=0: rsp_* are held stable and the FSM enters HOLD; no grants are issued.
- Pointer: unchanged on any cycle without a transfer.
- ctx_clear:
  - All contexts <= Red on the edge; no grant that cycle.
  - A pending response still follows the normal drain/hold rules.
  - trans_cnt is unaffected.
- Contexts are independent: a transfer for requester i never modifies context[j], j≠i.
- trans_cnt:
  - Increments by 1 on each transfer where next ≠ s.
  - Saturates at all-ones.
  - Cleared only by rst.
- Reset mid-operation: asynchronously returns all state to reset values. Any in-flight response is dropped.
- Input rule: requesters must hold req_valid/req_in stable until granted. The block does not check this.

Test Plan:
- Reset, then requester 0 sends in=1 → next cycle rsp_valid=1, rsp_id=0, rsp_out=1, rsp_state=0 (Blue), trans_cnt=1. Requester 0 then sends in=0 → rsp_out=1, rsp_state=0, trans_cnt=1.
- All 4 requesters valid continuously with rsp_ready=1 → grant order 0,1,2,3,0,… with one response per cycle; each requester's state toggles independently when in=1.
- rsp_ready=0 for 3 cycles while requests are pending → rsp_* stable, req_ready=0 throughout. Releasing rsp_ready resumes grants the same cycle, with the next grant going to the requester after the held rsp_id.
- Requester 2 driven to Blue, then ctx_clear pulsed while requests are valid → no grant that cycle. Requester 2 then sends in=2 → rsp_out=2, rsp_state=1.
- Force 2^CNTW-1 transitions (CNTW=4 build) → trans_cnt stays at 15 after further toggles.
- Assert rst asynchronously mid-stream with rsp_valid=1 → rsp_valid drops immediately. All contexts read back Red: in=0 → rsp_out=2.
